// File: rtl/nfc_command_programpage.sv
// rtl/nfc_command_programpage.sv - page-program command engine (80h, 5 addr, data-out, 10h, R/B# wait)
module nfc_command_programpage #(
    parameter int          NumberOfWays = 4,
    parameter logic [5:0]  CommandID    = 6'b000110,
    parameter logic [4:0]  TargetID     = 5'b00101,
    parameter logic [15:0] RBLowTimeout = 16'd1024
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic [4:0]              iSourceID,
    input  logic [31:0]             iAddress,
    input  logic [15:0]             iLength,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    output logic                    oStart,
    output logic                    oLastStep,
    input  logic [15:0]             iWriteData,
    input  logic                    iWriteLast,
    input  logic                    iWriteValid,
    output logic                    oWriteReady,
    output logic [7:0]              oACG_Command,
    output logic [2:0]              oACG_CommandOption,
    input  logic [7:0]              iACG_Ready,
    input  logic [7:0]              iACG_LastStep,
    output logic [NumberOfWays-1:0] oACG_TargetWay,
    output logic [15:0]             oACG_NumOfData,
    output logic                    oACG_CASelect,
    output logic [39:0]             oACG_CAData,
    output logic [15:0]             oACG_WriteData,
    output logic                    oACG_WriteLast,
    output logic                    oACG_WriteValid,
    input  logic                    iACG_WriteReady,
    input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_READY    = 3'd1,
        S_CMD1     = 3'd2,
        S_ADDR     = 3'd3,
        S_DATA     = 3'd4,
        S_CMD2     = 3'd5,
        S_WAITLOW  = 3'd6,
        S_WAITHIGH = 3'd7
    } state_t;

    localparam logic [7:0]  CMD_CA       = 8'h08;
    localparam logic [7:0]  CMD_DATA_OUT = 8'h20;
    localparam logic [39:0] CA_PROGRAM1  = 40'h80_00_00_00_00;
    localparam logic [39:0] CA_PROGRAM2  = 40'h10_00_00_00_00;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_cmd_ready;
    logic                    r_last_step;
    logic [7:0]              r_command;
    logic [NumberOfWays-1:0] r_target_way;
    logic [15:0]             r_num_of_data;
    logic                    r_ca_select;
    logic [39:0]             r_ca_data;
    logic [23:0]             r_address;
    logic [15:0]             r_length;
    logic [15:0]             r_wait_cnt;
    logic [NumberOfWays-1:0] r_rb_stage;
    logic                    r_rb_sync;

    logic                    w_idle;
    logic                    w_accept;
    logic                    w_in_data;
    logic [7:0]              w_command_next;
    logic                    w_ca_select_next;
    logic [39:0]             w_ca_data_next;
    logic [15:0]             w_num_of_data_next;
    logic                    w_unused;

    // RESET behaves like READY for acceptance since oCMDReady already reads 1 there
    assign w_idle    = (r_state == S_READY) || (r_state == S_RESET);
    assign oStart    = (iOpcode == CommandID) && (iTargetID == TargetID) && iCMDValid;
    assign w_accept  = w_idle && oStart;
    assign w_in_data = (r_state == S_DATA);

    assign oCMDReady          = r_cmd_ready;
    assign oLastStep          = r_last_step;
    assign oACG_Command       = r_command;
    assign oACG_CommandOption = 3'b000;
    assign oACG_TargetWay     = r_target_way;
    assign oACG_NumOfData     = r_num_of_data;
    assign oACG_CASelect      = r_ca_select;
    assign oACG_CAData        = r_ca_data;

    assign oWriteReady     = w_in_data & iACG_WriteReady;
    assign oACG_WriteData  = iWriteData;
    assign oACG_WriteLast  = w_in_data & iWriteLast;
    assign oACG_WriteValid = w_in_data & iWriteValid;

    assign w_unused = ^{iSourceID, iAddress[31:24], iACG_Ready,
                        iACG_LastStep[7:6], iACG_LastStep[4], iACG_LastStep[2:0]};

    // state register
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state: each ACG step holds until its done bit, then the R/B# low/high wait
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET, S_READY: w_next_state = w_accept ? S_CMD1 : S_READY;
            S_CMD1:     if (iACG_LastStep[3]) w_next_state = S_ADDR;
            S_ADDR:     if (iACG_LastStep[3]) w_next_state = S_DATA;
            S_DATA:     if (iACG_LastStep[5]) w_next_state = S_CMD2;
            S_CMD2:     if (iACG_LastStep[3]) w_next_state = S_WAITLOW;
            // busy is only trusted once the counter has moved, so WAITLOW lasts at least 2 cycles;
            // a busy pulse too short to be seen falls through to the timeout
            S_WAITLOW:  if ((!r_rb_sync && (r_wait_cnt != 16'd0)) || (r_wait_cnt >= RBLowTimeout))
                            w_next_state = S_WAITHIGH;
            S_WAITHIGH: if (r_rb_sync) w_next_state = S_READY;
            default:    w_next_state = S_READY;
        endcase
    end

    // ACG step fields decoded from the next state so they appear registered with the step
    always_comb begin
        w_command_next     = 8'h00;
        w_ca_select_next   = 1'b1;
        w_ca_data_next     = 40'h0;
        w_num_of_data_next = 16'h0;
        case (w_next_state)
            S_CMD1: begin
                w_command_next   = CMD_CA;
                w_ca_select_next = 1'b1;
                w_ca_data_next   = CA_PROGRAM1;
            end
            S_ADDR: begin
                w_command_next     = CMD_CA;
                w_ca_select_next   = 1'b0;
                w_ca_data_next     = {16'h0000, r_address};
                w_num_of_data_next = 16'd4;
            end
            S_DATA: begin
                w_command_next     = CMD_DATA_OUT;
                w_ca_select_next   = 1'b0;
                w_num_of_data_next = r_length;
            end
            S_CMD2: begin
                w_command_next   = CMD_CA;
                w_ca_select_next = 1'b1;
                w_ca_data_next   = CA_PROGRAM2;
            end
            default: begin
                w_command_next     = 8'h00;
                w_ca_select_next   = 1'b1;
                w_ca_data_next     = 40'h0;
                w_num_of_data_next = 16'h0;
            end
        endcase
    end

    // registered ACG request, ready/completion flags
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_command     <= 8'h00;
            r_ca_select   <= 1'b1;
            r_ca_data     <= 40'h0;
            r_num_of_data <= 16'h0;
            r_cmd_ready   <= 1'b1;
            r_last_step   <= 1'b0;
        end else begin
            r_command     <= w_command_next;
            r_ca_select   <= w_ca_select_next;
            r_ca_data     <= w_ca_data_next;
            r_num_of_data <= w_num_of_data_next;
            r_cmd_ready   <= (w_next_state == S_READY);
            r_last_step   <= (r_state == S_WAITHIGH) && r_rb_sync;
        end
    end

    // way select tracks the host while idle and freezes once a program is under way
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_target_way <= '0;
        end else if (w_idle) begin
            r_target_way <= iWaySelect;
        end
    end

    // capture row address and beat count on acceptance
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_address <= 24'h0;
            r_length  <= 16'h0;
        end else if (w_accept) begin
            r_address <= iAddress[23:0];
            r_length  <= iLength;
        end
    end

    // WAITLOW dwell counter, cleared whenever the engine is elsewhere
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_wait_cnt <= 16'h0;
        end else if (r_state == S_WAITLOW) begin
            if (r_wait_cnt != 16'hFFFF) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end else begin
            r_wait_cnt <= 16'h0;
        end
    end

    // two-flop R/B# synchroniser on the selected way; idles high (ready)
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_rb_stage <= {NumberOfWays{1'b1}};
            r_rb_sync  <= 1'b1;
        end else begin
            r_rb_stage <= r_target_way & iACG_ReadyBusy;
            r_rb_sync  <= |r_rb_stage;
        end
    end

endmodule

// File: doc/nfc_command_programpage.md
# nfc_command_programpage

Page-program command engine for the NAND flash controller: the write-direction counterpart of the page-read command block. On an accepted program request it drives the atomic command generator (ACG) through CMD 80h → 5 address cycles → data-out burst → CMD 10h, then waits for the selected way's R/B# to fall and rise before pulsing completion. It sits beside the other NFC command blocks, shares the ACG handshake bus, and forwards the host write stream to the ACG during the data phase.

## Interface
- NumberOfWays, 4, number of NAND ways (width of way vectors)
- CommandID, 6'b000110, iOpcode value this block responds to
- TargetID, 5'b00101, iTargetID value this block responds to
- RBLowTimeout, 16'd1024, max cycles to wait for R/B# low before treating busy as already elapsed
- iSystemClock  in  1  system clock; one clock domain
- iReset  in  1  reset, asynchronous, active-low
- iOpcode / iTargetID / iSourceID  in  6/5/5  command fields (iSourceID unused)
- iAddress  in  32  row address; [23:0] used
- iLength  in  16  data-out beat count, passed to ACG NumOfData
- iCMDValid  in  1  command valid
- oCMDReady  out  1  high only in READY
- iWaySelect  in  NumberOfWays  one-hot target way, sampled in READY
- oStart  out  1  combinational: opcode match & target match & iCMDValid
- oLastStep  out  1  one-cycle completion pulse
- iWriteData / iWriteLast / iWriteValid  in  16/1/1  host write stream
- oWriteReady  out  1  iACG_WriteReady gated by DATA state
- oACG_Command  out  8  one-hot step request: bit3 command/address, bit5 data-out
- oACG_CommandOption  out  3  always 0
- iACG_Ready / iACG_LastStep  in  8/8  ACG ready and per-step done
- oACG_TargetWay  out  NumberOfWays  registered way select
- oACG_NumOfData  out  16  step length
- oACG_CASelect  out  1  1 = command latch, 0 = address/data
- oACG_CAData  out  40  [39:32] first byte on bus
- oACG_WriteData / oACG_WriteLast / oACG_WriteValid  out  16/1/1  forwarded stream
- iACG_WriteReady  in  1  ACG accepts write beat
- iACG_ReadyBusy  in  NumberOfWays  raw per-way R/B# (1 = ready)

## Operation
- States: RESET → READY → CMD1 → ADDR → DATA → CMD2 → WAITLOW → WAITHIGH → READY.
- READY: oCMDReady=1, outputs idle, oACG_TargetWay ← iWaySelect; on oStart latch iAddress, iLength, go CMD1.
- CMD1: Command=8'h08, CASelect=1, CAData=40'h80_00_00_00_00, NumOfData=0; advance on iACG_LastStep[3].
- ADDR: Command=8'h08, CASelect=0, NumOfData=4, CAData={16'h0000, rAddress[23:0]}; advance on iACG_LastStep[3].
- DATA: Command=8'h20, CASelect=0, NumOfData=rLength; oACG_Write* = iWrite* combinational, oWriteReady=iACG_WriteReady; outside DATA oACG_WriteValid=0, oWriteReady=0. Advance on iACG_LastStep[5].
- CMD2: Command=8'h08, CASelect=1, CAData=40'h10_00_00_00_00; advance on iACG_LastStep[3].
- WAITLOW: Command=0; 16-bit counter from 0; go WAITHIGH when synced busy=0 or counter reaches RBLowTimeout.
- WAITHIGH: go READY when synced busy=1; oLastStep=1 for that transition cycle.
- Unused state encodings → READY. Command/CA outputs registered from next state.

## Timing
- Reset values: oCMDReady=1, oLastStep=0, oACG_Command=0, CommandOption=0, TargetWay=0, NumOfData=0, CASelect=1, CAData=0, rAddress/rLength=0, counter=0, sync regs=1.
- Accept: oStart high in READY at edge N → CMD1 registered, oCMDReady=0 at N+1.
- Each step's Command held until that bit's iACG_LastStep; next step registered the cycle after.
- R/B# sync: two flops (TargetWay & iACG_ReadyBusy, then OR-reduce); 2-cycle latency.
- Minimum WAITLOW dwell 2 cycles; busy pulse shorter than 2 cycles may be missed → timeout path covers it.
- oLastStep: exactly one cycle, coincident with oCMDReady returning to 1 next cycle.
- iCMDValid ignored outside READY; iWaySelect change mid-operation ignored.
- iReset low at any point: immediate return to reset values; in-flight ACG step abandoned.

## Test plan
- Nominal: opcode 000110, target 00101, addr 0x00123456, len 2047, way 0001 → CAData 80h, then {0000,123456h} NumOfData=4, data step NumOfData=2047, CAData 10h, oLastStep one pulse after R/B# low then high.
- Mismatch: opcode 000100 valid → oStart=0, stays READY, oCMDReady=1.
- Data path: 4 beats with iACG_WriteReady toggling → beats forwarded unchanged, oWriteReady=0 outside DATA.
- Timeout: R/B# held high, RBLowTimeout=16 → WAITHIGH after 16 cycles, oLastStep next cycle.
- Way mask: way 0100, busy only on way 0010 → no WAITLOW exit except timeout.
- Reset in DATA: iReset low → all outputs to reset values asynchronously; after release, READY and new command accepted.
